m_ifetch: RTL and testbench

Instruction fetch stage directly upstream of the dual-port instruction memory. It owns the PC, drives port A's read address every cycle, and absorbs the memory's fixed 1-cycle synchronous read latency. Returned words go into a small instruction buffer, presented to decode with a valid/ready handshake. Supports branch/jump redirect with flush of buffered and in-flight words.

---
 rtl/m_ifetch_pkg.sv | 25 ++
 rtl/m_ifetch_if.sv | 23 ++
 rtl/m_ifetch_fifo.sv | 53 +++++
 rtl/m_ifetch.sv | 89 ++++++++
 tb/tb_m_ifetch.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/m_ifetch_pkg.sv
// rtl/m_ifetch_pkg.sv - shared fetch config: reset PC default, instruction width, imem geometry macros
`ifndef IMEM_ADDRW
`define IMEM_ADDRW 10
`endif
`ifndef IMEM_ENTRIES
`define IMEM_ENTRIES (1 << `IMEM_ADDRW)
`endif

package m_ifetch_pkg;

  localparam int unsigned INST_W           = 32;
  localparam int unsigned PC_W             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch result: the PC travels with its instruction word.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/m_ifetch_if.sv
// rtl/m_ifetch_if.sv - fetch stage bus: redirect, imem port A read, decode handshake
interface m_ifetch_if;

  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_raddr_o;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_rdata_i, inst_ready_i,
    output imem_raddr_o, inst_valid_o, inst_o, inst_pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_rdata_i, inst_ready_i,
    input  imem_raddr_o, inst_valid_o, inst_o, inst_pc_o
  );

endinterface

// File: rtl/m_ifetch_fifo.sv
// rtl/m_ifetch_fifo.sv - DEPTH x {pc,inst} FIFO with flush; caller guarantees no overflow/underflow
module m_ifetch_fifo
  import m_ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output logic         head_valid,
  output fetch_entry_t head_data
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Push into the slot being popped is safe: the head is read from the old contents.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/m_ifetch.sv
// rtl/m_ifetch.sv - instruction fetch: PC, issue/in-flight tracking, buffer to decode
// Optional IFETCH_STALL_CNT_EN adds stall_cnt_o (saturating count of valid & !ready cycles).
module m_ifetch
  import m_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  m_ifetch_if.master  bus
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [CW-1:0] count;
  logic          head_valid;
  fetch_entry_t  head;
  fetch_entry_t  capture;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;
  logic [1:0]    unused_pc_lsb;

  assign unused_pc_lsb = bus.redirect_pc_i[1:0];

  assign pop       = head_valid & bus.inst_ready_i;
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q);
  // pop moved to the right-hand side so the comparison never underflows.
  assign issue     = !bus.redirect_i &&
                     (occupancy < ((CW+1)'(BUF_DEPTH) + (CW+1)'(pop)));
  assign push      = inflight_q & !bus.redirect_i;
  assign capture   = '{pc: inflight_pc_q, inst: bus.imem_rdata_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (bus.redirect_i) begin
      pc_q       <= word_align(bus.redirect_pc_i);
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q          <= pc_q + 32'd4;
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  m_ifetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .push       (push),
    .push_data  (capture),
    .pop        (pop),
    .flush      (bus.redirect_i),
    .count      (count),
    .head_valid (head_valid),
    .head_data  (head)
  );

  assign bus.imem_raddr_o = pc_q;
  assign bus.inst_valid_o = head_valid;
  assign bus.inst_o       = head.inst;
  assign bus.inst_pc_o    = head.pc;

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (head_valid && !bus.inst_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_ifetch.sv
// tb/tb_m_ifetch.sv - randomized + directed bench for m_ifetch against a queue-based fetch model
module tb_m_ifetch;
  import m_ifetch_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  m_ifetch_if bus ();

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  m_ifetch #(
    .RESET_PC  (RPC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Instruction memory port A: no enable, one-cycle synchronous read.
  always @(posedge clk) bus.imem_rdata_i <= word_at(bus.imem_raddr_o);

  // Model: every issued PC with the cycle it was issued; it is deliverable two cycles later.
  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } issued_t;

  issued_t     q[$];
  logic [31:0] m_raddr = RPC;
  logic [31:0] m_stall = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic model_valid();
    return (q.size() > 0) && (q[0].cyc + 2 <= cyc);
  endfunction

  // Compare the current cycle, drive this cycle's inputs, then advance the model over the next edge.
  task automatic step(input logic rst_v, input logic rdy, input logic redir, input logic [31:0] rpc);
    logic mv;
    @(negedge clk);
    mv = model_valid();
    chk("raddr", bus.imem_raddr_o, m_raddr);
    chk("valid", {31'b0, bus.inst_valid_o}, {31'b0, mv});
    if (mv) begin
      chk("inst_pc", bus.inst_pc_o, q[0].pc);
      chk("inst", bus.inst_o, word_at(q[0].pc));
    end
`ifdef IFETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    rst_n             = rst_v;
    bus.inst_ready_i  = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    if (!rst_v) begin
      q.delete();
      m_raddr = RPC;
      m_stall = '0;
    end else begin
      if (mv && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (mv && rdy) void'(q.pop_front());
      if (redir) begin
        q.delete();
        m_raddr = {rpc[31:2], 2'b00};
      end else if (q.size() < DEPTH) begin
        q.push_back('{pc: m_raddr, cyc: cyc});
        m_raddr = m_raddr + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    bus.inst_ready_i  = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;

    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    // Reset release: first valid two cycles later, sequential PCs.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("lit_valid_c1", {31'b0, bus.inst_valid_o}, 32'd0);
    step(1, 1, 0, 0);
    chk("lit_valid_c2", {31'b0, bus.inst_valid_o}, 32'd1);
    chk("lit_pc_c2", bus.inst_pc_o, 32'h0000_0000);
    chk("lit_inst_c2", bus.inst_o, 32'h1000_0000);
    step(1, 1, 0, 0);
    chk("lit_pc_c3", bus.inst_pc_o, 32'h0000_0004);
    step(1, 1, 0, 0);

    // Stall for 10 cycles: fetch freezes at 20 with head 12.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("lit_stall_raddr", bus.imem_raddr_o, 32'h0000_0014);
    chk("lit_stall_pc", bus.inst_pc_o, 32'h0000_000C);
    chk("lit_stall_inst", bus.inst_o, 32'h1000_0003);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // Redirect with a full buffer; target misaligned.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0103);
    step(1, 1, 0, 0);
    chk("lit_redir_r1", {31'b0, bus.inst_valid_o}, 32'd0);
    step(1, 1, 0, 0);
    chk("lit_redir_r2", {31'b0, bus.inst_valid_o}, 32'd0);
    step(1, 1, 0, 0);
    chk("lit_redir_valid", {31'b0, bus.inst_valid_o}, 32'd1);
    chk("lit_redir_pc", bus.inst_pc_o, 32'h0000_0100);
    chk("lit_redir_inst", bus.inst_o, 32'h1000_0040);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);

    // Redirect coinciding with a pop.
    step(1, 1, 1, 32'h0000_0200);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("lit_pop_redir_pc", bus.inst_pc_o, 32'h0000_0200);

    // Wrap at the top of the address space.
    step(1, 1, 1, 32'hFFFF_FFF8);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("lit_wrap_0", bus.inst_pc_o, 32'hFFFF_FFF8);
    step(1, 1, 0, 0);
    chk("lit_wrap_1", bus.inst_pc_o, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("lit_wrap_2", bus.inst_pc_o, 32'h0000_0000);
    chk("lit_wrap_2_inst", bus.inst_o, 32'h1000_0000);

    // Asynchronous reset mid-stream.
    step(0, 1, 0, 0);
    #1;
    chk("lit_async_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    chk("lit_async_raddr", bus.imem_raddr_o, RPC);

    // Release with decode stalled: cycles 2..8 are stall cycles.
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
`ifdef IFETCH_STALL_CNT_EN
    chk("lit_stall_cnt7", stall_cnt, 32'd7);
`endif
    step(0, 0, 0, 0);
    #1;
`ifdef IFETCH_STALL_CNT_EN
    chk("lit_stall_cnt_clr", stall_cnt, 32'd0);
`endif
    chk("lit_reset_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    step(1, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic        r_rst;
      logic        r_rdy;
      logic        r_redir;
      logic [31:0] r_pc;
      r_rst   = ($urandom_range(0, 299) != 0);
      r_rdy   = ($urandom_range(0, 9) < 7);
      r_redir = ($urandom_range(0, 24) == 0);
      r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(r_rst, r_rdy, r_redir, r_pc);
    end
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
